// File: rtl/lif_neuron.sv
`default_nettype none
// ============================================================================
// Module      : lif_neuron
// Description : Leaky integrate-and-fire neuron with two states, INTEGRATE
//               and REFRACTORY.
//               - INTEGRATE: the signed weights of the channels that spiked
//                 this cycle are summed and added to the membrane potential
//                 V. The result saturates to N bits and then has the leak
//                 applied. The neuron fires when the post-leak value reaches
//                 firing_threshold.
//               - REFRACTORY: inputs are ignored and only the leak acts on V.
// Ports       :
//   clk                 in   rising-edge clock
//   rst_n               in   asynchronous active-low reset
//   firing_threshold    in   [N-1:0]   signed firing threshold
//   syn_weights         in   [M*S-1:0] signed weight of channel i at [i*S +: S]
//   spike_in            in   [M-1:0]   per-channel spike events
//   leak_value          in   [N-2:0]   unsigned leak magnitude per tick
//   leak_period         in   [L-1:0]   cycles between leak ticks (0 = off)
//   refrac_period       in   [R-1:0]   refractory cycles after a spike
//   reset_mode          in   0: V<=0 on fire, 1: V<=V-threshold on fire
//   spike_out           out  one-cycle registered spike
//   membrane_potential  out  [N-1:0]   registered signed potential V
//   refractory          out  high while in REFRACTORY
// Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron #(
    parameter int N = 8,
    parameter int S = 4,
    parameter int M = 4,
    parameter int R = 4,
    parameter int L = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   firing_threshold,
    input  logic [M*S-1:0] syn_weights,
    input  logic [M-1:0]   spike_in,
    input  logic [N-2:0]   leak_value,
    input  logic [L-1:0]   leak_period,
    input  logic [R-1:0]   refrac_period,
    input  logic           reset_mode,
    output logic           spike_out,
    output logic [N-1:0]   membrane_potential,
    output logic           refractory
);

    // Internal arithmetic width. It holds the sum of all M weights plus V
    // without overflow, and also V +/- leak and V - threshold.
    localparam int c_W = N + $clog2(M) + 1;

    localparam logic [0:0] c_INTEGRATE  = 1'b0;
    localparam logic [0:0] c_REFRACTORY = 1'b1;

    localparam logic signed [c_W-1:0] c_VMAX = {{(c_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [c_W-1:0] c_VMIN = {{(c_W-N+1){1'b1}}, {(N-1){1'b0}}};
    localparam logic signed [c_W-1:0] c_ZERO = '0;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic signed [c_W-1:0] sext_n(input logic [N-1:0] v);
        return {{(c_W-N){v[N-1]}}, v};
    endfunction

    function automatic logic [N-1:0] sat_n(input logic signed [c_W-1:0] x);
        logic [N-1:0] y;
        if (x > c_VMAX) begin
            y = c_VMAX[N-1:0];
        end else if (x < c_VMIN) begin
            y = c_VMIN[N-1:0];
        end else begin
            y = x[N-1:0];
        end
        return y;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [0:0]   r_state;
    logic [N-1:0] r_v;
    logic         r_spike;
    logic [R-1:0] r_refrac_cnt;
    logic [L-1:0] r_leak_cnt;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic signed [c_W-1:0] w_weight_ext [M];
    logic signed [c_W-1:0] w_sum;
    logic signed [c_W-1:0] w_full;
    logic        [N-1:0]   w_vs;
    logic signed [c_W-1:0] w_leak_ext;
    logic signed [c_W-1:0] w_leak_dec;
    logic signed [c_W-1:0] w_leak_inc;
    logic        [N-1:0]   w_vl;
    logic                  w_leak_tick;
    logic        [L-1:0]   w_next_leak_cnt;
    logic                  w_fire;
    logic signed [c_W-1:0] w_sub;
    logic        [N-1:0]   w_v_after_fire;
    logic        [0:0]     w_next_state;
    logic        [N-1:0]   w_next_v;
    logic                  w_next_spike;
    logic        [R-1:0]   w_next_refrac_cnt;

    // Sign-extend every channel weight to the internal width.
    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_chan
            assign w_weight_ext[gi] = {{(c_W-S){syn_weights[gi*S+S-1]}},
                                       syn_weights[gi*S +: S]};
        end
    endgenerate

    // Synaptic sum. Spikes are ignored entirely while refractory.
    always_comb begin
        w_sum = '0;
        if (r_state == c_INTEGRATE) begin
            for (int i = 0; i < M; i++) begin
                if (spike_in[i]) begin
                    w_sum = w_sum + w_weight_ext[i];
                end
            end
        end
    end

    assign w_full = w_sum + sext_n(r_v);
    assign w_vs   = sat_n(w_full);

    // Leak tick generator. It runs in both states. A zero period holds the
    // counter at zero and produces no ticks.
    always_comb begin
        w_leak_tick     = 1'b0;
        w_next_leak_cnt = '0;
        if (leak_period != '0) begin
            if (r_leak_cnt >= leak_period - L'(1)) begin
                w_leak_tick = 1'b1;
            end else begin
                w_next_leak_cnt = r_leak_cnt + L'(1);
            end
        end
    end

    // Leak moves the value toward zero but never past it. The direction is
    // chosen by the sign of the stored V, not by the sign of the new sum.
    assign w_leak_ext = {{(c_W-N+1){1'b0}}, leak_value};
    assign w_leak_dec = sext_n(w_vs) - w_leak_ext;
    assign w_leak_inc = sext_n(w_vs) + w_leak_ext;

    always_comb begin
        w_vl = w_vs;
        if (w_leak_tick) begin
            if (!r_v[N-1] && (r_v != '0)) begin
                w_vl = (w_leak_dec < c_ZERO) ? '0 : w_leak_dec[N-1:0];
            end else if (r_v[N-1]) begin
                w_vl = (w_leak_inc > c_ZERO) ? '0 : w_leak_inc[N-1:0];
            end
        end
    end

    // Fire decision and post-fire potential.
    assign w_fire         = (r_state == c_INTEGRATE) &&
                            ($signed(w_vl) >= $signed(firing_threshold));
    assign w_sub          = sext_n(w_vl) - sext_n(firing_threshold);
    assign w_v_after_fire = reset_mode ? sat_n(w_sub) : '0;

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state      = r_state;
        w_next_v          = w_vl;
        w_next_spike      = 1'b0;
        w_next_refrac_cnt = r_refrac_cnt;
        case (r_state)
            c_INTEGRATE: begin
                if (w_fire) begin
                    w_next_spike = 1'b1;
                    w_next_v     = w_v_after_fire;
                    // The period is captured only here. Later changes to
                    // the input do not affect a refractory interval that
                    // is already running.
                    if (refrac_period != '0) begin
                        w_next_state      = c_REFRACTORY;
                        w_next_refrac_cnt = refrac_period;
                    end
                end
            end
            c_REFRACTORY: begin
                w_next_refrac_cnt = r_refrac_cnt - R'(1);
                // The last refractory cycle is the one that consumes the
                // final count. The next edge then accepts inputs again.
                if (r_refrac_cnt <= R'(1)) begin
                    w_next_state      = c_INTEGRATE;
                    w_next_refrac_cnt = '0;
                end
            end
            default: begin
                w_next_state      = c_INTEGRATE;
                w_next_refrac_cnt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_INTEGRATE;
            r_v          <= '0;
            r_spike      <= 1'b0;
            r_refrac_cnt <= '0;
            r_leak_cnt   <= '0;
        end else begin
            r_state      <= w_next_state;
            r_v          <= w_next_v;
            r_spike      <= w_next_spike;
            r_refrac_cnt <= w_next_refrac_cnt;
            r_leak_cnt   <= w_next_leak_cnt;
        end
    end

    assign spike_out          = r_spike;
    assign membrane_potential = r_v;
    assign refractory         = (r_state == c_REFRACTORY);

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron.sv
`default_nettype none
// ============================================================================
// Module      : tb_lif_neuron
// Description : Scoreboard testbench for lif_neuron (N=8, S=4, M=4, R=4,
//               L=4). Each driven cycle pushes the expected outputs from an
//               integer reference model. A monitor pops one entry after
//               every rising edge and compares it with the DUT outputs.
//               The directed scenarios also compare against fixed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_neuron;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  firing_threshold;
    logic [15:0] syn_weights;
    logic [3:0]  spike_in;
    logic [6:0]  leak_value;
    logic [3:0]  leak_period;
    logic [3:0]  refrac_period;
    logic        reset_mode;
    logic        spike_out;
    logic [7:0]  membrane_potential;
    logic        refractory;

    always #5 clk = ~clk;

    lif_neuron #(.N(8), .S(4), .M(4), .R(4), .L(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .firing_threshold   (firing_threshold),
        .syn_weights        (syn_weights),
        .spike_in           (spike_in),
        .leak_value         (leak_value),
        .leak_period        (leak_period),
        .refrac_period      (refrac_period),
        .reset_mode         (reset_mode),
        .spike_out          (spike_out),
        .membrane_potential (membrane_potential),
        .refractory         (refractory)
    );

    // Stimulus configuration, copied onto the DUT pins at each falling edge.
    logic        cfg_rst;
    logic [7:0]  cfg_thr;
    logic [15:0] cfg_w;
    logic [3:0]  cfg_sp;
    logic [6:0]  cfg_lv;
    logic [3:0]  cfg_lp;
    logic [3:0]  cfg_rp;
    logic        cfg_rm;

    typedef struct {
        logic spike;
        int   v;
        logic refr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   started  = 1'b0;

    // Reference model state: potential, remaining refractory cycles,
    // and leak counter.
    int m_v, m_refr, m_lc;

    function automatic int clamp8(input int x);
        if (x > 127)  return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    task automatic model_and_push();
        exp_t e;
        int   sum, vs, vl, thr, lv, wv;
        bit   tick;
        logic [3:0] nib;
        if (!rst_n) begin
            m_v = 0; m_refr = 0; m_lc = 0;
            e.spike = 1'b0;
        end else begin
            tick = 1'b0;
            if (leak_period == 0) begin
                m_lc = 0;
            end else if (m_lc >= int'(leak_period) - 1) begin
                tick = 1'b1;
                m_lc = 0;
            end else begin
                m_lc = m_lc + 1;
            end
            sum = 0;
            if (m_refr == 0) begin
                for (int i = 0; i < 4; i++) begin
                    if (spike_in[i]) begin
                        nib = syn_weights[i*4 +: 4];
                        wv  = int'(nib);
                        if (wv >= 8) wv = wv - 16;
                        sum = sum + wv;
                    end
                end
            end
            vs  = clamp8(m_v + sum);
            vl  = vs;
            lv  = int'(leak_value);
            thr = int'($signed(firing_threshold));
            if (tick) begin
                if (m_v > 0)      vl = (vs - lv > 0) ? vs - lv : 0;
                else if (m_v < 0) vl = (vs + lv < 0) ? vs + lv : 0;
            end
            if (m_refr == 0 && vl >= thr) begin
                e.spike = 1'b1;
                m_v     = reset_mode ? clamp8(vl - thr) : 0;
                m_refr  = int'(refrac_period);
            end else begin
                e.spike = 1'b0;
                m_v     = vl;
                if (m_refr > 0) m_refr = m_refr - 1;
            end
        end
        e.v    = m_v;
        e.refr = (m_refr > 0);
        sb.push_back(e);
    endtask

    // One clock cycle of stimulus, applied at the falling edge.
    task automatic step();
        @(negedge clk);
        rst_n            = cfg_rst;
        firing_threshold = cfg_thr;
        syn_weights      = cfg_w;
        spike_in         = cfg_sp;
        leak_value       = cfg_lv;
        leak_period      = cfg_lp;
        refrac_period    = cfg_rp;
        reset_mode       = cfg_rm;
        model_and_push();
        started = 1'b1;
    endtask

    task automatic do_reset();
        cfg_rst = 1'b0;
        step();
        cfg_rst = 1'b1;
    endtask

    // Assert reset in the middle of a cycle and check that it acts at once.
    task automatic async_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (spike_out !== 1'b0 || membrane_potential !== 8'd0 || refractory !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: actual spike=%0b V=%0d refr=%0b, required spike=0 V=0 refr=0",
                     spike_out, $signed(membrane_potential), refractory);
        end
        model_and_push();
        cfg_rst = 1'b1;
    endtask

    // Directed check of the outputs produced by the edge after the last step.
    task automatic check_now(input string name, input int ev, input logic es, input logic er);
        logic [7:0] ev8;
        ev8 = 8'(ev);
        @(posedge clk);
        #2;
        n_checks++;
        if (spike_out !== es || membrane_potential !== ev8 || refractory !== er) begin
            n_errors++;
            $display("FAIL %s: actual spike=%0b V=%0d refr=%0b, required spike=%0b V=%0d refr=%0b",
                     name, spike_out, $signed(membrane_potential), refractory, es, ev, er);
        end
    endtask

    task automatic common_cfg();
        cfg_thr = 8'd20;  cfg_w  = 16'h7777; cfg_sp = 4'h0;
        cfg_lv  = 7'd0;   cfg_lp = 4'd0;     cfg_rp = 4'd0; cfg_rm = 1'b0;
    endtask

    // Scoreboard monitor.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL scoreboard_underflow: actual V=%0d with no expected entry, required one entry",
                             $signed(membrane_potential));
                end else begin
                    e = sb.pop_front();
                    if (spike_out !== e.spike || membrane_potential !== e.v[7:0] ||
                        refractory !== e.refr) begin
                        n_errors++;
                        $display("FAIL cycle_compare: actual spike=%0b V=%0d refr=%0b, expected spike=%0b V=%0d refr=%0b",
                                 spike_out, $signed(membrane_potential), refractory,
                                 e.spike, e.v, e.refr);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        m_v = 0; m_refr = 0; m_lc = 0;
        rst_n = 1'b0;
        firing_threshold = '0; syn_weights = '0; spike_in = '0;
        leak_value = '0; leak_period = '0; refrac_period = '0; reset_mode = 1'b0;
        common_cfg();
        cfg_rst = 1'b0;

        // Power-on reset.
        step();
        step();
        cfg_rst = 1'b1;

        // Single volley crosses the threshold and resets V to zero.
        common_cfg();
        do_reset();
        cfg_sp = 4'hF;
        step(); check_now("fire_reset_zero", 0, 1'b1, 1'b0);
        cfg_sp = 4'h0;
        step(); check_now("spike_one_cycle", 0, 1'b0, 1'b0);

        // Negative saturation.
        common_cfg();
        cfg_thr = 8'd127; cfg_w = 16'h8888;
        do_reset();
        cfg_sp = 4'hF;
        for (int k = 1; k <= 6; k++) begin
            step();
            check_now("neg_saturate", (-32 * k < -128) ? -128 : -32 * k, 1'b0, 1'b0);
        end

        // Subtractive reset with a refractory period.
        common_cfg();
        cfg_rm = 1'b1; cfg_rp = 4'd3;
        do_reset();
        cfg_sp = 4'hF;
        step(); check_now("refr_fire1", 8, 1'b1, 1'b1);
        step(); check_now("refr_hold1", 8, 1'b0, 1'b1);
        cfg_rp = 4'd9;  // a change during the period must have no effect
        step(); check_now("refr_hold2", 8, 1'b0, 1'b1);
        step(); check_now("refr_last",  8, 1'b0, 1'b0);
        cfg_rp = 4'd3;
        step(); check_now("refr_fire2", 16, 1'b1, 1'b1);

        // Leak decays toward zero and stops there.
        common_cfg();
        cfg_thr = 8'd100; cfg_lp = 4'd4; cfg_lv = 7'd3; cfg_w = 16'h0037;
        do_reset();
        cfg_sp = 4'h3;
        step(); check_now("leak_load", 10, 1'b0, 1'b0);
        cfg_sp = 4'h0;
        repeat (3) step(); check_now("leak_t1", 7, 1'b0, 1'b0);
        repeat (4) step(); check_now("leak_t2", 4, 1'b0, 1'b0);
        repeat (4) step(); check_now("leak_t3", 1, 1'b0, 1'b0);
        repeat (4) step(); check_now("leak_t4", 0, 1'b0, 1'b0);
        repeat (4) step(); check_now("leak_t5", 0, 1'b0, 1'b0);

        // Reset during REFRACTORY, then integrate from zero.
        common_cfg();
        cfg_rp = 4'd3;
        do_reset();
        cfg_sp = 4'hF;
        step(); check_now("pre_reset_fire", 0, 1'b1, 1'b1);
        step();
        async_reset();
        step(); check_now("post_reset_fire", 0, 1'b1, 1'b1);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            if (k % 25 == 0) begin
                if ($urandom_range(0, 3) == 0) cfg_thr = 8'($urandom);
                else                           cfg_thr = 8'($urandom_range(5, 100));
                cfg_w  = 16'($urandom);
                cfg_lv = 7'($urandom_range(0, 12));
                cfg_lp = 4'($urandom_range(0, 6));
                cfg_rp = 4'($urandom_range(0, 5));
                cfg_rm = 1'($urandom_range(0, 1));
            end
            cfg_sp = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) async_reset();
            else                            step();
        end

        cfg_sp = 4'h0;
        step();
        @(posedge clk);
        #3;
        started = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: actual %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lif_neuron.md
LIF_NEURON -- requirements
Module: lif_neuron

Interface
REQ-001 SHALL have parameter N, default 8: membrane potential and threshold width in bits, two's complement.
REQ-002 SHALL have parameter S, default 4: synaptic weight width in bits, two's complement, with S <= N.
REQ-003 SHALL have parameter M, default 4: number of synaptic input channels, M >= 1.
REQ-004 SHALL have parameter R, default 4: refractory period counter width in bits.
REQ-005 SHALL have parameter L, default 4: leak period counter width in bits.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port firing_threshold, input, N bits: signed firing threshold.
REQ-009 SHALL have port syn_weights, input, M*S bits: signed weight of channel i in bits [i*S +: S].
REQ-010 SHALL have port spike_in, input, M bits: per-channel spike event for the current cycle.
REQ-011 SHALL have port leak_value, input, N-1 bits: unsigned leak magnitude applied per leak tick.
REQ-012 SHALL have port leak_period, input, L bits: cycles between leak ticks; 0 disables leak.
REQ-013 SHALL have port refrac_period, input, R bits: refractory length in cycles; 0 means no refractory period.
REQ-014 SHALL have port reset_mode, input, 1 bit: 0 resets to zero after a spike, 1 subtracts the threshold after a spike.
REQ-015 SHALL have port spike_out, output, 1 bit: registered spike, high for exactly one cycle per firing.
REQ-016 SHALL have port membrane_potential, output, N bits: registered signed membrane potential V.
REQ-017 SHALL have port refractory, output, 1 bit: high while in the REFRACTORY state.

Function
REQ-018 SHALL implement two states, INTEGRATE and REFRACTORY, and SHALL enter INTEGRATE on reset.
REQ-019 SHALL, in INTEGRATE, sign-extend each weight whose spike_in bit is 1 and sum them at width N+clog2(M)+1 with no intermediate overflow.
REQ-020 SHALL add V to the sum at full width, then saturate the result to [-2^(N-1), 2^(N-1)-1] to form Vs.
REQ-021 SHALL apply the leak to Vs on a leak tick: V>0 gives max(Vs-leak_value,0); V<0 gives min(Vs+leak_value,0); V==0 leaves it unchanged; the leak SHALL never cross zero.
REQ-022 SHALL keep a leak counter: when leak_period==0 the counter is held at 0 with no ticks; otherwise a tick occurs when counter >= leak_period-1 and the counter then wraps to 0, else it increments.
REQ-023 SHALL run the leak counter and apply leak ticks in both states.
REQ-024 SHALL fire when the post-leak value Vl >= firing_threshold (signed compare) in INTEGRATE, setting spike_out to 1 on the next edge.
REQ-025 SHALL, on firing, set V to 0 if reset_mode==0, or to saturate(Vl - firing_threshold) if reset_mode==1.
REQ-026 SHALL, on firing with refrac_period != 0, enter REFRACTORY with the refractory counter loaded to refrac_period; with refrac_period==0 it SHALL remain in INTEGRATE.
REQ-027 SHALL, when not firing, set V to Vl and spike_out to 0.
REQ-028 SHALL, in REFRACTORY, ignore spike_in, keep spike_out at 0, apply only leak to V, and decrement the counter each cycle.
REQ-029 SHALL return to INTEGRATE after exactly refrac_period cycles in REFRACTORY; the first input accepted is on cycle refrac_period+1 after the firing edge.
REQ-030 SHALL latch refrac_period only at the firing edge, so that mid-period changes have no effect.
REQ-031 SHALL fire on every INTEGRATE cycle when firing_threshold <= 0 and Vl >= threshold; this is legal behaviour.

Reset
REQ-032 SHALL, while rst_n==0 and asynchronously, force V=0, spike_out=0, refractory=0, state INTEGRATE, the refractory counter to 0, and the leak counter to 0.
REQ-033 SHALL let reset override any in-progress firing or refractory period; after release, the first edge behaves as INTEGRATE from V=0.

Verification
Common settings unless stated: N=8, S=4, M=4, leak_period=0, refrac_period=0, reset_mode=0.
REQ-034 SHALL cover: assert rst_n low mid-stream -> spike_out=0, V=0, refractory=0 immediately, without waiting for clk.
REQ-035 SHALL cover: threshold=20, all weights 7, spike_in=1111 for one cycle -> fire, so spike_out=1 for one cycle and V=0.
REQ-036 SHALL cover: threshold=127, all weights -8, spike_in=1111 held -> V=-32,-64,-96,-128, then V held at -128 (saturated), with no fire.
REQ-037 SHALL cover: reset_mode=1, refrac_period=3, threshold=20, weights 7, spike_in=1111 each cycle -> fire with V=8, refractory=1 for 3 cycles with V=8 and inputs ignored, then V=36 -> fire again with V=16.
REQ-038 SHALL cover: threshold=100, leak_period=4, leak_value=3, one cycle of weights 7 and 3 -> V=10, then at successive ticks V=7,4,1,0 and V stays 0.
REQ-039 SHALL cover: rst_n pulsed low during REFRACTORY -> on release, refractory=0, and spike_in=1111 with weights 7 on the next edge gives V=28 -> fire (threshold 20).
